mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: the data port has fixed priority over instruction fetch,
// one shared memory access at a time, with a wait-counter timeout and a sticky error flag.
module mem_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        dm_ack_q, dm_ack_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (dm_req_i) begin
                    state_d     = DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    cnt_d       = 8'd0;
                end else if (if_req_i) begin
                    state_d     = IF_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = 32'd0;
                    cnt_d       = 8'd0;
                end
            end
            IF_BUSY, DM_BUSY: begin
                // An ack on the same cycle the counter hits the limit still completes normally.
                if (mem_ack_i || cnt_q == TIMEOUT) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_ack_i) begin
                        err_d = 1'b1;
                    end
                    if (state_q == DM_BUSY) begin
                        dm_rdata_d = mem_ack_i ? mem_rdata_i : 32'd0;
                        dm_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_ack_i ? mem_rdata_i : 32'd0;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            dm_rdata_q  <= 32'd0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_ack_o    = dm_ack_q;
    assign err_o       = err_q;
    assign stall_o     = (if_req_i & ~if_ack_q) | (dm_req_i & ~dm_ack_q);

endmodule
